// File: rtl/msrv32_lsu_ctrl_if.sv
// msrv32_lsu_ctrl_if: data-memory req/ack bus between the LSU controller (master) and memory (slave).
interface msrv32_lsu_ctrl_if;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_wmask_out;
    logic        dmem_ack_in;
    logic [31:0] dmem_rdata_in;
    modport master (
        output dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
        input  dmem_ack_in, dmem_rdata_in
    );
    modport slave (
        input  dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_wmask_out,
        output dmem_ack_in, dmem_rdata_in
    );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// msrv32_lsu_ctrl: load/store controller issuing one req/ack data-memory access at a time.
module msrv32_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_n_in,
  input  logic              ls_valid_in,
  input  logic              ls_is_store_in,
  input  logic              flush_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  input  logic [1:0]        load_size_in,
  input  logic              load_unsigned_in,
  msrv32_lsu_ctrl_if.master dmem,
  output logic [31:0]       load_data_out,
  output logic              load_valid_out,
  output logic              done_out,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic              timeout_out
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic        we_q, we_d, uns_q, uns_d, flushed_q, flushed_d, misaligned_q, misaligned_d;
  logic        misaligned, accept, ack, expire;
  logic [31:0] st_data, w, ext;
  logic [3:0]  st_mask;
  assign misaligned = (load_size_in == 2'b01 && addr_in[0]) || (load_size_in[1] && addr_in[1:0] != 2'b00);
  assign accept     = state_q == IDLE && ls_valid_in && !flush_in && !misaligned;
  assign ack        = state_q == REQ && dmem.dmem_ack_in;
  assign st_data    = load_size_in == 2'b00 ? {4{store_data_in[7:0]}} :
                      load_size_in == 2'b01 ? {2{store_data_in[15:0]}} : store_data_in;
  assign st_mask    = !ls_is_store_in       ? 4'b0000 :
                      load_size_in == 2'b00 ? 4'b0001 << addr_in[1:0] :
                      load_size_in == 2'b01 ? 4'b0011 << addr_in[1:0] : 4'b1111;
  assign w          = dmem.dmem_rdata_in >> {off_q, 3'b000};
  assign ext        = size_q == 2'b00 ? {{24{!uns_q && w[7]}}, w[7:0]} :
                      size_q == 2'b01 ? {{16{!uns_q && w[15]}}, w[15:0]} : w;
  always_comb begin
    state_d      = accept ? REQ : ack ? DONE : expire ? IDLE : state_q == DONE ? IDLE : state_q;
    addr_d       = accept ? {addr_in[31:2], 2'b00} : addr_q;
    we_d         = accept ? ls_is_store_in : we_q;
    wdata_d      = accept ? (ls_is_store_in ? st_data : 32'h0) : wdata_q;
    wmask_d      = accept ? st_mask : wmask_q;
    size_d       = accept ? load_size_in : size_q;
    uns_d        = accept ? load_unsigned_in : uns_q;
    off_d        = accept ? addr_in[1:0] : off_q;
    flushed_d    = state_d == IDLE ? 1'b0 : flushed_q || (state_q == REQ && flush_in);
    load_data_d  = ack && !we_q && !flushed_d ? ext : load_data_q;
    misaligned_d = state_q == IDLE && ls_valid_in && !flush_in && misaligned;
  end
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      flushed_q    <= 1'b0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      flushed_q    <= flushed_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
    end
  end
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;
  assign expire = state_q == REQ && !dmem.dmem_ack_in && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d  = accept ? '0 : state_q == REQ && !dmem.dmem_ack_in ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end
  assign timeout_out = timeout_q;
`else
  assign expire      = 1'b0;
  assign timeout_out = 1'b0;
`endif
  assign dmem.dmem_req_out   = state_q == REQ;
  assign dmem.dmem_we_out    = we_q;
  assign dmem.dmem_addr_out  = addr_q;
  assign dmem.dmem_wdata_out = wdata_q;
  assign dmem.dmem_wmask_out = wmask_q;
  assign load_data_out       = load_data_q;
  assign done_out            = state_q == DONE && !flushed_q;
  assign load_valid_out      = state_q == DONE && !flushed_q && !we_q;
  assign stall_out           = accept || state_q == REQ;
  assign misaligned_out      = misaligned_q;
endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// tb_msrv32_lsu_ctrl: directed self-checking bench for the LSU controller.
module tb_msrv32_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid = 1'b0, ls_is_store = 1'b0, flush = 1'b0, load_unsigned = 1'b0;
  logic [31:0] addr = '0, store_data = '0;
  logic [1:0]  load_size = '0;
  logic [31:0] load_data;
  logic        load_valid, done, stall, misaligned, timeout;
  int          pass_n = 0, total_n = 0;
  msrv32_lsu_ctrl_if bus();
  msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .ls_valid_in           (ls_valid),
    .ls_is_store_in        (ls_is_store),
    .flush_in              (flush),
    .addr_in               (addr),
    .store_data_in         (store_data),
    .load_size_in          (load_size),
    .load_unsigned_in      (load_unsigned),
    .dmem                  (bus),
    .load_data_out         (load_data),
    .load_valid_out        (load_valid),
    .done_out              (done),
    .stall_out             (stall),
    .misaligned_out        (misaligned),
    .timeout_out           (timeout)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u);
    ls_valid = 1'b1;
    ls_is_store = st;
    addr = a;
    store_data = d;
    load_size = sz;
    load_unsigned = u;
    #1 chk("stall_accept", stall, 1);
    cyc();
    ls_valid = 1'b0;
  endtask
  task automatic ack_now(input logic [31:0] rd);
    bus.dmem_ack_in = 1'b1;
    bus.dmem_rdata_in = rd;
    cyc();
    bus.dmem_ack_in = 1'b0;
    bus.dmem_rdata_in = '0;
  endtask
  initial begin
    bus.dmem_ack_in = 1'b0;
    bus.dmem_rdata_in = '0;
    cyc();
    cyc();
    chk("rst_req", bus.dmem_req_out, 0);
    chk("rst_we", bus.dmem_we_out, 0);
    chk("rst_addr", bus.dmem_addr_out, 0);
    chk("rst_wdata", bus.dmem_wdata_out, 0);
    chk("rst_wmask", bus.dmem_wmask_out, 0);
    chk("rst_ldata", load_data, 0);
    chk("rst_outs", {load_valid, done, stall, misaligned, timeout}, 0);
    rst_n = 1'b1;
    cyc();
    issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    chk("t1_req1", bus.dmem_req_out, 1);
    chk("t1_addr", bus.dmem_addr_out, 32'h100);
    chk("t1_we", bus.dmem_we_out, 0);
    chk("t1_wmask", bus.dmem_wmask_out, 4'b0000);
    chk("t1_stall1", stall, 1);
    cyc();
    chk("t1_req2", bus.dmem_req_out, 1);
    chk("t1_stall2", stall, 1);
    chk("t1_done_early", done, 0);
    cyc();
    chk("t1_req3", bus.dmem_req_out, 1);
    chk("t1_stall3", stall, 1);
    ack_now(32'hDEADBEEF);
    chk("t1_req_off", bus.dmem_req_out, 0);
    chk("t1_lvalid", load_valid, 1);
    chk("t1_done", done, 1);
    chk("t1_ldata", load_data, 32'hDEADBEEF);
    chk("t1_stall_done", stall, 0);
    cyc();
    chk("t1_lvalid_pulse", load_valid, 0);
    chk("t1_done_pulse", done, 0);
    chk("t1_ldata_hold", load_data, 32'hDEADBEEF);
    issue(1'b0, 32'h103, 32'h0, 2'b00, 1'b0);
    chk("t2_addr", bus.dmem_addr_out, 32'h100);
    ack_now(32'h80112233);
    chk("t2_lvalid_s", load_valid, 1);
    chk("t2_ldata_s", load_data, 32'hFFFFFF80);
    cyc();
    issue(1'b0, 32'h103, 32'h0, 2'b00, 1'b1);
    ack_now(32'h80112233);
    chk("t2_ldata_u", load_data, 32'h00000080);
    cyc();
    issue(1'b0, 32'h102, 32'h0, 2'b01, 1'b0);
    ack_now(32'h80011234);
    chk("t2_ldata_half", load_data, 32'hFFFF8001);
    cyc();
    issue(1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0);
    chk("t3_req", bus.dmem_req_out, 1);
    chk("t3_addr", bus.dmem_addr_out, 32'h200);
    chk("t3_we", bus.dmem_we_out, 1);
    chk("t3_wdata", bus.dmem_wdata_out, 32'hABCDABCD);
    chk("t3_wmask", bus.dmem_wmask_out, 4'b1100);
    ack_now(32'h0);
    chk("t3_done", done, 1);
    chk("t3_lvalid", load_valid, 0);
    chk("t3_ldata_keep", load_data, 32'hFFFF8001);
    cyc();
    chk("t3_done_pulse", done, 0);
    issue(1'b1, 32'h301, 32'h12345678, 2'b00, 1'b0);
    chk("t3b_wdata", bus.dmem_wdata_out, 32'h78787878);
    chk("t3b_wmask", bus.dmem_wmask_out, 4'b0010);
    ack_now(32'h0);
    chk("t3b_done", done, 1);
    cyc();
    ls_valid = 1'b1;
    ls_is_store = 1'b0;
    addr = 32'h101;
    load_size = 2'b10;
    #1 chk("t4_stall", stall, 0);
    cyc();
    ls_valid = 1'b0;
    chk("t4_mis", misaligned, 1);
    chk("t4_req", bus.dmem_req_out, 0);
    cyc();
    chk("t4_mis_pulse", misaligned, 0);
    ls_valid = 1'b1;
    addr = 32'h203;
    load_size = 2'b01;
    #1 chk("t4h_stall", stall, 0);
    cyc();
    ls_valid = 1'b0;
    chk("t4h_mis", misaligned, 1);
    chk("t4h_req", bus.dmem_req_out, 0);
    cyc();
    ack_now(32'h55555555);
    chk("idle_ack_done", done, 0);
    chk("idle_ack_ldata", load_data, 32'hFFFF8001);
    issue(1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
    chk("t5_req", bus.dmem_req_out, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t5_req_rst", bus.dmem_req_out, 0);
    chk("t5_addr_rst", bus.dmem_addr_out, 0);
    chk("t5_ldata_rst", load_data, 0);
    ack_now(32'h12345678);
    chk("t5_done", done, 0);
    chk("t5_lvalid", load_valid, 0);
    chk("t5_ldata", load_data, 0);
    chk("t5_stall", stall, 0);
    issue(1'b0, 32'h500, 32'h0, 2'b10, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5f_req_held", bus.dmem_req_out, 1);
    ack_now(32'h11111111);
    chk("t5f_done", done, 0);
    chk("t5f_lvalid", load_valid, 0);
    chk("t5f_ldata", load_data, 0);
    cyc();
    ls_valid = 1'b1;
    flush = 1'b1;
    #1 chk("t5i_stall", stall, 0);
    cyc();
    ls_valid = 1'b0;
    flush = 1'b0;
    chk("t5i_req", bus.dmem_req_out, 0);
    issue(1'b0, 32'h504, 32'h0, 2'b10, 1'b0);
    ack_now(32'hCAFEF00D);
    chk("t5n_lvalid", load_valid, 1);
    chk("t5n_ldata", load_data, 32'hCAFEF00D);
    cyc();
    issue(1'b0, 32'h600, 32'h0, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_req", bus.dmem_req_out, 1);
      chk("t6_timeout_low", timeout, 0);
      cyc();
    end
`ifdef LSU_TIMEOUT_EN
    chk("t6_timeout", timeout, 1);
    chk("t6_req_drop", bus.dmem_req_out, 0);
    chk("t6_stall", stall, 0);
    chk("t6_done", done, 0);
    cyc();
    chk("t6_timeout_pulse", timeout, 0);
`else
    chk("t6_still_req", bus.dmem_req_out, 1);
    chk("t6_no_timeout", timeout, 0);
    ack_now(32'h0BADF00D);
    chk("t6_late_ack", load_data, 32'h0BADF00D);
    cyc();
`endif
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
